// File: rtl/pipe_addsub.sv
// Pipelined integer add/subtract unit with optional signed saturation.
//
// The carry chain is cut into STAGES chunks of CW = WIDTH/STAGES bits. Stage k sums chunk k
// and hands its carry to stage k+1. Operand chunks that have not been summed yet travel
// alongside in a skewed pipeline. The last stage feeds the output register. Saturation and
// the flags are applied in front of that register. Latency is STAGES cycles at one beat per
// cycle. A single global enable stalls every stage, including bubbles, under backpressure.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready depends only on out_valid/out_ready
//   a, b                 operands (WIDTH bits)
//   op                   00 add, 01 sub, 10 sat add, 11 sat sub (op[1] ignored if !SAT_EN)
//   out_valid/out_ready  result handshake
//   result               final (possibly saturated) result
//   carry_out            carry out of the MSB (sub: 1 = no borrow)
//   overflow             signed overflow of the unsaturated sum
//   zero                 result == 0 after saturation
module pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  logic             en;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;

  // The whole pipe moves together; no bubble collapsing.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * CW;

    // Stage inputs. Stage 0 takes them straight from the ports; later stages register them.
    logic              v_q;
    logic              sat_q;   // only op[1] is needed past stage 0
    logic              c_q;
    logic [WIDTH-1:Lo] a_q;     // operand chunks not yet summed
    logic [WIDTH-1:Lo] bp_q;    // B' = b or ~b
    logic [Lo+CW-1:0]  sum_nxt; // chunks 0..k of the sum
    logic [CW:0]       chunk;

    assign chunk = {1'b0, a_q[Lo +: CW]} + {1'b0, bp_q[Lo +: CW]} + {{CW{1'b0}}, c_q};

    if (k == 0) begin : g_in
      assign v_q     = in_valid;
      assign sat_q   = op[1];
      assign c_q     = op[0];
      assign a_q     = a;
      assign bp_q    = op[0] ? ~b : b;
      assign sum_nxt = chunk[CW-1:0];
    end else begin : g_reg
      logic [Lo-1:0] sum_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          sat_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          bp_q  <= '0;
          sum_q <= '0;
        end else if (en) begin
          v_q   <= g_stage[k-1].v_q;
          sat_q <= g_stage[k-1].sat_q;
          c_q   <= g_stage[k-1].chunk[CW];
          a_q   <= g_stage[k-1].a_q[WIDTH-1:Lo];
          bp_q  <= g_stage[k-1].bp_q[WIDTH-1:Lo];
          sum_q <= g_stage[k-1].sum_nxt;
        end
      end

      assign sum_nxt = {chunk[CW-1:0], sum_q};
    end
  end

  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             overflow_d;
  logic             zero_d;
  logic             a_msb;
  logic             bp_msb;
  logic             sat_en;
  logic             last_v;

  assign sum_raw = g_stage[Last].sum_nxt;
  assign carry_d = g_stage[Last].chunk[CW];
  assign a_msb   = g_stage[Last].a_q[WIDTH-1];
  assign bp_msb  = g_stage[Last].bp_q[WIDTH-1];
  assign sat_en  = SAT_EN && g_stage[Last].sat_q;
  assign last_v  = g_stage[Last].v_q;

  always_comb begin
    overflow_d = (a_msb == bp_msb) && (sum_raw[WIDTH-1] != a_msb);
    result_d   = sum_raw;
    // Overflow direction follows the sign of A: positive overflow clamps to max, negative to min.
    if (sat_en && overflow_d) begin
      result_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_d = (result_d == '0);
  end

  // Data is only captured for valid beats so a drained unit keeps showing its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= last_v;
      if (last_v) begin
        result_q   <= result_d;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: a 4-stage and a 1-stage instance share all inputs
// and are each checked against a plain-arithmetic reference model.
module tb_pipe_addsub;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;

  logic         in_ready4, out_valid4, carry4, ovf4, zero4;
  logic [W-1:0] result4;
  logic         in_ready1, out_valid1, carry1, ovf1, zero1;
  logic [W-1:0] result1;

  int errors = 0;
  int checks = 0;

  pipe_addsub #(.WIDTH(W), .STAGES(4), .SAT_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
    .op(op), .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .carry_out(carry4), .overflow(ovf4), .zero(zero4)
  );

  pipe_addsub #(.WIDTH(W), .STAGES(1), .SAT_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .op(op), .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .carry_out(carry1), .overflow(ovf1), .zero(zero1)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  // Reference: true signed/unsigned arithmetic, then clamp.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [1:0] o);
    longint   sx, sy, sr;
    logic [W:0] u;
    exp_t     e;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[0]) begin
      sr  = sx - sy;
      u   = {1'b0, x} - {1'b0, y};
      e.c = (x >= y);
    end else begin
      sr  = sx + sy;
      u   = {1'b0, x} + {1'b0, y};
      e.c = u[W];
    end
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.r = u[W-1:0];
    if (o[1] && e.o) e.r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      4: return W'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // Issue one beat into an empty pipe and collect each DUT's first output and latency.
  task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                          output exp_t got4, output int lat4,
                          output exp_t got1, output int lat1);
    a = x; b = y; op = o;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat4 = -1; lat1 = -1;
    got4 = '0; got1 = '0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (lat1 < 0 && out_valid1) begin
        lat1 = c;
        got1 = {result1, carry1, ovf1, zero1};
      end
      if (lat4 < 0 && out_valid4) begin
        lat4 = c;
        got4 = {result4, carry4, ovf4, zero4};
      end
      if (lat4 >= 0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || result4 !== '0 || carry4 !== 1'b0 || ovf4 !== 1'b0 ||
        zero4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs4: got v=%b r=%h c=%b o=%b z=%b, want all 0",
               out_valid4, result4, carry4, ovf4, zero4);
    end
    checks++;
    if (out_valid1 !== 1'b0 || result1 !== '0 || carry1 !== 1'b0 || ovf1 !== 1'b0 ||
        zero1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs1: got v=%b r=%h c=%b o=%b z=%b, want all 0",
               out_valid1, result1, carry1, ovf1, zero1);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", in_ready4, in_ready1);
    end
    tick();
  endtask

  task automatic test_addsub();
    logic [W-1:0] va[12];
    logic [W-1:0] vb[12];
    logic [1:0]   vo[12];
    exp_t         g4, g1, e;
    int           l4, l1;
    va = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
           32'h8000_0000, 32'h0000_FFFF, 32'h00FF_FFFF, 32'h8000_0000, 32'h8000_0000,
           32'h0000_0000};
    vb = '{32'd1, 32'd7, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
           32'h8000_0000, 32'h8000_0000};
    vo = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 12; i++) begin
      e = model(va[i], vb[i], vo[i]);
      send_one(va[i], vb[i], vo[i], g4, l4, g1, l1);
      checks++;
      if (g4 !== e) begin
        errors++;
        $display("FAIL addsub4[%0d]: got r=%h c=%b o=%b z=%b want r=%h c=%b o=%b z=%b",
                 i, g4.r, g4.c, g4.o, g4.z, e.r, e.c, e.o, e.z);
      end
      checks++;
      if (l4 != 4) begin
        errors++;
        $display("FAIL latency4[%0d]: got %0d want 4", i, l4);
      end
      checks++;
      if (g1 !== e) begin
        errors++;
        $display("FAIL addsub1[%0d]: got r=%h c=%b o=%b z=%b want r=%h c=%b o=%b z=%b",
                 i, g1.r, g1.c, g1.o, g1.z, e.r, e.c, e.o, e.z);
      end
      checks++;
      if (l1 != 1) begin
        errors++;
        $display("FAIL latency1[%0d]: got %0d want 1", i, l1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int           sent = 0;
    int           got = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held = '0;
    op = 2'b00;
    b  = W'(100);
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid  = (sent < 8);
      a         = W'(sent);
      out_ready = !(c >= 6 && c <= 8);
      #1;
      checks++;
      if (in_ready4 !== !(out_valid4 && !out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, in_ready4,
                 !(out_valid4 && !out_ready));
      end
      if (stall_prev) begin
        checks++;
        if (out_valid4 !== 1'b1 || result4 !== held) begin
          errors++;
          $display("FAIL b2b_stall_hold c=%0d: got v=%b r=%h want v=1 r=%h", c, out_valid4,
                   result4, held);
        end
      end
      if (out_valid4 && out_ready) begin
        checks++;
        if (result4 !== W'(100 + got)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %0d want %0d", got, result4, 100 + got);
        end
        got++;
      end
      if (in_valid && in_ready4) sent++;
      stall_prev = out_valid4 && !out_ready;
      held       = result4;
      tick();
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 8", got);
    end
    idle(6);
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_duplicate: got out_valid=%b after drain want 0", out_valid4);
    end
  endtask

  task automatic test_random();
    exp_t q4[$];
    exp_t q1[$];
    exp_t e, g, h4, h1;
    logic st4 = 1'b0;
    logic st1 = 1'b0;
    h4 = '0; h1 = '0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      a  = pick();
      b  = pick();
      op = 2'($urandom_range(0, 3));
      #1;
      // 4-stage instance
      checks++;
      if (in_ready4 !== (!out_valid4 || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready4 c=%0d: got %b", c, in_ready4);
      end
      g = {result4, carry4, ovf4, zero4};
      if (st4) begin
        checks++;
        if (out_valid4 !== 1'b1 || g !== h4) begin
          errors++;
          $display("FAIL rand_hold4 c=%0d: got v=%b r=%h want v=1 r=%h", c, out_valid4,
                   result4, h4.r);
        end
      end
      if (out_valid4 && out_ready) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious4 c=%0d: got r=%h want no beat", c, result4);
        end else begin
          e = q4.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL rand_data4 c=%0d: got r=%h c=%b o=%b z=%b want r=%h c=%b o=%b z=%b",
                     c, g.r, g.c, g.o, g.z, e.r, e.c, e.o, e.z);
          end
        end
      end
      if (in_valid && in_ready4) q4.push_back(model(a, b, op));
      st4 = out_valid4 && !out_ready;
      h4  = g;
      // 1-stage instance
      checks++;
      if (in_ready1 !== (!out_valid1 || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready1 c=%0d: got %b", c, in_ready1);
      end
      g = {result1, carry1, ovf1, zero1};
      if (st1) begin
        checks++;
        if (out_valid1 !== 1'b1 || g !== h1) begin
          errors++;
          $display("FAIL rand_hold1 c=%0d: got v=%b r=%h want v=1 r=%h", c, out_valid1,
                   result1, h1.r);
        end
      end
      if (out_valid1 && out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious1 c=%0d: got r=%h want no beat", c, result1);
        end else begin
          e = q1.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL rand_data1 c=%0d: got r=%h c=%b o=%b z=%b want r=%h c=%b o=%b z=%b",
                     c, g.r, g.c, g.o, g.z, e.r, e.c, e.o, e.z);
          end
        end
      end
      if (in_valid && in_ready1) q1.push_back(model(a, b, op));
      st1 = out_valid1 && !out_ready;
      h1  = g;
      tick();
    end
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d/%0d beats outstanding want 0/0", q4.size(), q1.size());
    end
  endtask

  task automatic test_mid_reset();
    exp_t g4, g1;
    int   l4, l1;
    int   stale4 = 0;
    int   stale1 = 0;
    idle(4);
    op = 2'b00;
    b  = W'(1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = W'(10 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || result4 !== '0 || carry4 !== 1'b0 || ovf4 !== 1'b0 ||
        zero4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async4: got v=%b r=%h c=%b o=%b z=%b want all 0",
               out_valid4, result4, carry4, ovf4, zero4);
    end
    checks++;
    if (out_valid1 !== 1'b0 || result1 !== '0 || carry1 !== 1'b0 || ovf1 !== 1'b0 ||
        zero1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async1: got v=%b r=%h c=%b o=%b z=%b want all 0",
               out_valid1, result1, carry1, ovf1, zero1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid4) stale4++;
      if (out_valid1) stale1++;
    end
    checks++;
    if (stale4 != 0 || stale1 != 0) begin
      errors++;
      $display("FAIL midreset_stale: got %0d/%0d valid cycles want 0/0", stale4, stale1);
    end
    send_one(W'(3), W'(4), 2'b00, g4, l4, g1, l1);
    checks++;
    if (g4.r !== W'(7) || l4 != 4) begin
      errors++;
      $display("FAIL midreset_fresh4: got r=%0d lat=%0d want r=7 lat=4", g4.r, l4);
    end
    checks++;
    if (g1.r !== W'(7) || l1 != 1) begin
      errors++;
      $display("FAIL midreset_fresh1: got r=%0d lat=%0d want r=7 lat=1", g1.r, l1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addsub();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
